// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: control-flow types, 2-bit counter states
// and the saturating counter step.
package bp_pkg;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JUMP = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Saturating step toward taken (inc) or not-taken (dec).
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) res = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry,
// and a pop while empty does nothing.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next write slot; the top of stack sits just below it.
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == CNT_W'(0));

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters plus a return-address stack; combinational
// next-PC prediction for IF, trained by resolved control flow from ID.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ENTRIES   = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc_if,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [1:0]        upd_type,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  br_type_e          type_q   [ENTRIES];
  br_type_e          type_d   [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [ADDR_W-1:0] target_d [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];
  logic [1:0]        cnt_d    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic [ADDR_W-1:0] lk_seq;
  logic              upd_fire, up_hit;
  br_type_e          up_type;
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  assign lk_idx   = pc_if[IDX_W+1:2];
  assign lk_tag   = pc_if[ADDR_W-1:IDX_W+2];
  assign lk_seq   = pc_if + ADDR_W'(4);
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[ADDR_W-1:IDX_W+2];
  assign up_type  = br_type_e'(upd_type);
  assign upd_fire = upd_valid & en;
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign ras_push = upd_fire && (up_type == BR_CALL);
  assign ras_pop  = upd_fire && (up_type == BR_RET);

  // Lookup reads registered state only, so a same-cycle update is not visible yet.
  always_comb begin
    hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = 1'b0;
    pred_target = lk_seq;
    if (hit) begin
      case (type_q[lk_idx])
        BR_COND: begin
          pred_taken = cnt_q[lk_idx][1];
          if (cnt_q[lk_idx][1]) pred_target = target_q[lk_idx];
        end
        BR_JUMP, BR_CALL: begin
          pred_taken  = 1'b1;
          pred_target = target_q[lk_idx];
        end
        BR_RET: begin
          pred_taken  = 1'b1;
          pred_target = ras_empty ? target_q[lk_idx] : ras_top;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    type_d   = type_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (upd_fire) begin
      if (up_hit) begin
        if (up_type == BR_COND) begin
          cnt_d[up_idx] = cnt_next(cnt_q[up_idx], upd_taken);
          if (upd_taken) target_d[up_idx] = upd_target;
        end else begin
          type_d[up_idx]   = up_type;
          target_d[up_idx] = upd_target;
        end
      end else if (upd_taken || (up_type != BR_COND)) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        type_d[up_idx]   = up_type;
        target_d[up_idx] = upd_target;
        cnt_d[up_idx]    = upd_taken ? CNT_WT : CNT_WNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        type_q[i]   <= BR_COND;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      type_q   <= type_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (upd_pc + ADDR_W'(4)),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus random training, checked against
// a table-and-queue reference model.
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, upd_valid, upd_taken;
  logic [1:0]  upd_type;
  logic [31:0] pc_if, upd_pc, upd_target, pred_target;
  logic        hit, pred_taken;

  int checks   = 0;
  int failures = 0;

  bit          m_valid  [16];
  int unsigned m_tag    [16];
  int          m_type   [16];
  int unsigned m_target [16];
  int          m_cnt    [16];
  int unsigned m_ras    [$];

  branch_predictor #(.ADDR_W(32), .ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .pc_if(pc_if), .hit(hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_type(upd_type), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_ras.delete();
  endfunction

  function automatic void model_lookup(input int unsigned pc, output bit h, output bit tk,
                                       output int unsigned tg);
    int i = int'((pc / 4) % 16);
    h  = m_valid[i] && (m_tag[i] == pc / 64);
    tk = 0;
    tg = pc + 4;
    if (h) begin
      if (m_type[i] == 0) begin
        tk = (m_cnt[i] >= 2);
        if (tk) tg = m_target[i];
      end else begin
        tk = 1;
        tg = m_target[i];
        if (m_type[i] == 3 && m_ras.size() > 0) tg = m_ras[$];
      end
    end
  endfunction

  function automatic void model_update(input int unsigned pc, input int t, input bit tk,
                                       input int unsigned tg);
    int i = int'((pc / 4) % 16);
    if (m_valid[i] && m_tag[i] == pc / 64) begin
      if (t == 0) begin
        m_cnt[i] = tk ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (tk) m_target[i] = tg;
      end else begin
        m_type[i]   = t;
        m_target[i] = tg;
      end
    end else if (tk || t != 0) begin
      m_valid[i]  = 1;
      m_tag[i]    = pc / 64;
      m_type[i]   = t;
      m_target[i] = tg;
      m_cnt[i]    = tk ? 2 : 1;
    end
    if (t == 2) begin
      m_ras.push_back(pc + 4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (t == 3 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  // One clock: drive an update and a lookup, check lookup against the model, then train it.
  task automatic tick(input bit v, input logic [1:0] t, input logic [31:0] pc, input bit tk,
                      input logic [31:0] tg, input bit e, input logic [31:0] lpc);
    bit h, ptk;
    int unsigned ptg;
    upd_valid = v; upd_type = t; upd_pc = pc; upd_taken = tk; upd_target = tg;
    en = e; pc_if = lpc;
    @(negedge clk);
    model_lookup(lpc, h, ptk, ptg);
    check("hit", 32'(hit), 32'(h));
    check("pred_taken", 32'(pred_taken), 32'(ptk));
    check("pred_target", pred_target, ptg);
    @(posedge clk);
    if (v && e) model_update(pc, int'(t), tk, tg);
    #1;
    upd_valid = 1'b0;
    en = 1'b1;
  endtask

  // Idle clock with a lookup checked against fixed expectations.
  task automatic look(input string name, input logic [31:0] pc, input bit eh, input bit et,
                      input logic [31:0] etg);
    upd_valid = 1'b0;
    pc_if = pc;
    @(negedge clk);
    check({name, ".hit"}, 32'(hit), 32'(eh));
    check({name, ".taken"}, 32'(pred_taken), 32'(et));
    check({name, ".target"}, pred_target, etg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; upd_valid = 1'b0; upd_type = BR_COND; upd_taken = 1'b0;
    pc_if = 32'h40; upd_pc = '0; upd_target = '0;
    model_reset();
    #12 rst = 1'b0;

    look("reset", 32'h40, 0, 0, 32'h44);

    tick(1, BR_COND, 32'h40, 1, 32'h100, 1, 32'h40);
    look("cond_install", 32'h40, 1, 1, 32'h100);
    tick(1, BR_COND, 32'h40, 0, 32'h0, 1, 32'h40);
    tick(1, BR_COND, 32'h40, 0, 32'h0, 1, 32'h40);
    look("cond_snt", 32'h40, 1, 0, 32'h44);

    for (int k = 0; k < 3; k++) tick(1, BR_COND, 32'h40, 1, 32'h100, 1, 32'h40);
    tick(1, BR_COND, 32'h40, 0, 32'h0, 1, 32'h40);
    look("cond_wt", 32'h40, 1, 1, 32'h100);

    look("alias_miss", 32'h80, 0, 0, 32'h84);
    tick(1, BR_JUMP, 32'h80, 1, 32'h300, 1, 32'h80);
    look("alias_evict", 32'h40, 0, 0, 32'h44);
    look("jump_hit", 32'h80, 1, 1, 32'h300);

    tick(1, BR_CALL, 32'h200, 1, 32'h1000, 1, 32'h200);
    tick(1, BR_CALL, 32'h300, 1, 32'h2000, 1, 32'h300);
    tick(1, BR_RET,  32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_top", 32'h400, 1, 1, 32'h204);
    tick(1, BR_RET,  32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_empty", 32'h400, 1, 1, 32'h304);

    for (int k = 0; k < 5; k++) tick(1, BR_CALL, 32'h2004 + 32'(k) * 32'h100, 1, 32'h5000, 1, 32'h400);
    look("ras_push5", 32'h400, 1, 1, 32'h2408);
    tick(1, BR_RET, 32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_pop1", 32'h400, 1, 1, 32'h2308);
    tick(1, BR_RET, 32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_pop2", 32'h400, 1, 1, 32'h2208);
    tick(1, BR_RET, 32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_pop3", 32'h400, 1, 1, 32'h2108);
    tick(1, BR_RET, 32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_pop4", 32'h400, 1, 1, 32'h304);
    tick(1, BR_RET, 32'h400, 1, 32'h304, 1, 32'h400);
    look("ras_underflow", 32'h400, 1, 1, 32'h304);
    tick(1, BR_CALL, 32'h2004, 1, 32'h5000, 1, 32'h400);
    look("ras_after_uf", 32'h400, 1, 1, 32'h2008);

    tick(1, BR_CALL, 32'h2104, 1, 32'h5000, 0, 32'h400);
    tick(1, BR_COND, 32'h40, 1, 32'h100, 0, 32'h40);
    look("en0_ras", 32'h400, 1, 1, 32'h2008);
    look("en0_btb", 32'h40, 0, 0, 32'h44);

    tick(1, BR_COND, 32'h40, 1, 32'h100, 1, 32'h40);
    look("pre_rst", 32'h40, 1, 1, 32'h100);
    upd_valid = 1'b1; upd_type = BR_JUMP; upd_pc = 32'h80; upd_taken = 1'b1;
    upd_target = 32'h300; pc_if = 32'h40;
    #2 rst = 1'b1;
    #1;
    check("mid_rst.hit", 32'(hit), 32'd0);
    check("mid_rst.taken", 32'(pred_taken), 32'd0);
    check("mid_rst.target", pred_target, 32'h44);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    upd_valid = 1'b0;
    look("rst_discard", 32'h80, 0, 0, 32'h84);
    look("rst_ras", 32'h400, 0, 0, 32'h404);

    for (int n = 0; n < 600; n++) begin
      logic [1:0]  t;
      logic [31:0] pc, lpc;
      bit tk;
      t   = 2'($urandom_range(0, 3));
      tk  = (t == BR_COND) ? 1'($urandom_range(0, 1)) : 1'b1;
      pc  = 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 15)) * 32'h4 +
            32'($urandom_range(0, 3));
      lpc = 32'($urandom_range(0, 3)) * 32'h40 + 32'($urandom_range(0, 15)) * 32'h4 +
            32'($urandom_range(0, 3));
      tick(($urandom_range(0, 2) != 0), t, pc, tk, $urandom, ($urandom_range(0, 4) != 0), lpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the fixed PC_NEXT fetch policy in IF with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters and a return-address stack (RAS). It looks up the IF-stage PC combinationally and produces a predicted next PC. It is trained by the ID stage, where branches resolve against `rs_rt_equal`.

## Interface
Parameters:
- `ADDR_W`, 32, PC width in bits.
- `ENTRIES`, 16, BTB entries; a power of 2 and ≥2. `IDX_W = log2(ENTRIES)`.
- `RAS_DEPTH`, 4, return-stack entries; a power of 2 and ≥2.

Ports (the clock is `clk`; reset is asynchronous and active-high, port `rst`):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high; clears all predictor state
- `en`  in  1  stall control; when 0, no state update occurs
- `pc_if`  in  ADDR_W  fetch address being looked up
- `hit`  out  1  valid BTB entry whose tag matches `pc_if`
- `pred_taken`  out  1  predict redirect
- `pred_target`  out  ADDR_W  predicted next PC
- `upd_valid`  in  1  resolved control-flow instruction in ID
- `upd_pc`  in  ADDR_W  PC of the resolved instruction
- `upd_type`  in  2  BR_COND / BR_JUMP / BR_CALL / BR_RET
- `upd_taken`  in  1  actual direction (1 for all non-COND types)
- `upd_target`  in  ADDR_W  actual target

## Operation
- Index and tag:
  - index = `pc[IDX_W+1:2]`
  - tag = `pc[ADDR_W-1:IDX_W+2]`
  - `pc[1:0]` is ignored.
- BTB entry fields: `valid`, `tag`, `type[1:0]`, `target`, `cnt[1:0]`.
- Lookup (purely combinational from `pc_if` and registered state):
  - On a miss: `hit=0`, `pred_taken=0`, `pred_target=pc_if+4` (mod 2^ADDR_W).
  - On a hit with type COND: `pred_taken=cnt[1]`; `pred_target` = the entry target if taken, otherwise `pc_if+4`.
  - On a hit with type JUMP or CALL: `pred_taken=1`, `pred_target` = the entry target.
  - On a hit with type RET: `pred_taken=1`, `pred_target` = RAS top if the RAS is non-empty, otherwise the entry target.
- Update (applied only when `upd_valid & en`, at the clock edge):
  - Tag hit, COND: `cnt` increments if taken and decrements if not taken, saturating at 00 and 11. `target` is rewritten only when taken.
  - Tag hit, other types: `type` and `target` are rewritten.
  - Miss, and (`upd_taken` or type≠COND): the entry is installed, overwriting any entry at that index. Initial `cnt` is 10 if taken, 01 otherwise.
  - Miss, COND not taken: no allocation.
- RAS behaviour (driven by updates only, never by lookups):
  - CALL pushes `upd_pc+4`. A push while full overwrites the oldest entry (circular buffer); the count saturates at RAS_DEPTH.
  - RET pops. A pop while empty is a no-op and the count stays 0.
  - Only one RAS operation can occur per cycle.
- `en=0`: all state holds. Lookup outputs still follow `pc_if`.

## Timing
- Lookup latency is 0 cycles (combinational).
- An update becomes visible to lookups on the cycle after its edge.
- When a lookup and an update hit the same index in the same cycle, the lookup sees the pre-update state.
- Reset values:
  - Every entry: `valid=0`, `cnt=01`.
  - RAS: pointer 0, count 0.
  - Outputs (they are combinational): `hit=0`, `pred_taken=0`, `pred_target=pc_if+4`.
- Asserting `rst` mid-operation clears state immediately, without waiting for a clock edge. The outputs fall to their miss values in the same cycle, and any update in that cycle is discarded.

## Structure
- Package `bp_pkg` holds:
  - `upd_type` encodings: BR_COND=0, BR_JUMP=1, BR_CALL=2, BR_RET=3.
  - Counter constants: CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11.
- Sub-module `ras_stack`, parametrised on DEPTH and WIDTH, with push, pop, `top` and `empty`. It is instantiated once.
- The BTB is flop-based: per-entry registers with an asynchronous clear.

## Test plan
1. Reset, then `pc_if=0x40` → `hit=0`, `pred_taken=0`, `pred_target=0x44`.
2. Update COND at 0x40, taken, target 0x100. Next cycle, lookup 0x40 → `hit=1`, taken, target 0x100. Then two not-taken updates → `cnt=00`, `pred_taken=0`, target 0x44.
3. Three taken COND updates at 0x40 → `cnt=11`. One not-taken update → `cnt=10`, prediction is still taken to 0x100.
4. Aliasing (ENTRIES=16): 0x40 is installed. Lookup 0x80 (same index 0, different tag) → miss. A taken JUMP update at 0x80 with target 0x300 replaces the entry, so lookup 0x40 then misses.
5. RAS: CALL at 0x200, then CALL at 0x300 (stack holds 0x204, 0x304). RET update at 0x400 with target 0x304 pops, leaving 0x204 on top. Lookup 0x400 → target 0x204. With RAS_DEPTH=4: five pushes, then pops return the 5th, 4th, 3rd and 2nd pushed values, and a further pop is a no-op.
6. `upd_valid=1` with `en=0` → no state change. Asserting `rst` between clock edges after training → `hit` drops to 0 immediately.
